// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with
// registered read data. Accesses are strictly serialised, one at a time.
module ram_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_wr_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  // Handshake: a requester holds req with stable fields until its one-cycle
  // ack; the transaction is latched at grant, so later field changes are ignored.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   owner;
  logic   rr;
  logic   grant_valid;
  logic   grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    grant_valid = 1'b0;
    grant       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_valid = 1'b1;
          grant       = (req0 && req1) ? rr : req1;
          state_next  = ACCESS;
        end
      end
      // mem_wr_re still carries the latched op type during ACCESS
      ACCESS:  state_next = mem_wr_re ? RESP : CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= 1'b0;
      rr          <= 1'b0;
      mem_wr_re   <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      if (grant_valid) begin
        owner       <= grant;
        mem_wr_re   <= grant ? we1    : we0;
        mem_addr    <= grant ? addr1  : addr0;
        mem_data_in <= grant ? wdata1 : wdata0;
      end
      if (state == ACCESS) mem_wr_re <= 1'b0;
      if (state == CAPTURE) begin
        if (owner) rdata1 <= mem_data_out;
        else       rdata0 <= mem_data_out;
      end
      if (state == RESP) rr <= ~owner;
    end
  end

  assign ack0 = (state == RESP) && !owner;
  assign ack1 = (state == RESP) &&  owner;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a behavioural 32x8 RAM with registered
// read data, a vector table of single accesses, and multi-cycle corner sequences.
module tb_ram_port_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       mem_wr_re;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_wr_re(mem_wr_re), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  // Clock and RAM model (backdoor port used only while the arbiter is idle)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [32];
  logic       bd_we;
  logic [4:0] bd_addr;
  logic [7:0] bd_data;

  always @(posedge clk) begin
    if (bd_we)          ram[bd_addr]  <= bd_data;
    else if (mem_wr_re) ram[mem_addr] <= mem_data_in;
    if (!mem_wr_re)     mem_data_out  <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack0"}, 32'(ack0), 0);
    check({tag, "_ack1"}, 32'(ack1), 0);
    check({tag, "_rdata0"}, 32'(rdata0), 0);
    check({tag, "_rdata1"}, 32'(rdata1), 0);
    check({tag, "_wr_re"}, 32'(mem_wr_re), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_data_in"}, 32'(mem_data_in), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // One access by requester sel, called and returning at a negedge.
  // gap=1 inserts one idle cycle first; abuse=1 drops req and scrambles
  // the fields in the cycle after the sampling edge.
  task automatic run(input string name, input logic sel, input logic we,
                     input logic [4:0] addr, input logic [7:0] wdata,
                     input logic [7:0] exp_rd, input int exp_lat,
                     input bit gap, input bit abuse);
    logic [7:0] other_before;
    int cnt, wr_cnt, other_acks;
    bit seen;
    if (gap) @(negedge clk);
    other_before = sel ? rdata0 : rdata1;
    if (sel) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else     begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    cnt = 0; wr_cnt = 0; other_acks = 0; seen = 1'b0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (mem_wr_re) begin
        wr_cnt++;
        check({name, "_mem_addr"}, 32'(mem_addr), 32'(addr));
        check({name, "_mem_data_in"}, 32'(mem_data_in), 32'(wdata));
      end
      if (sel ? ack0 : ack1) other_acks++;
      if (sel ? ack1 : ack0) seen = 1'b1;
      else if (abuse && cnt == 1) begin
        if (sel) begin req1 = 1'b0; addr1 = ~addr; wdata1 = ~wdata; end
        else     begin req0 = 1'b0; addr0 = ~addr; wdata0 = ~wdata; end
      end
    end
    if (sel) req1 = 1'b0; else req0 = 1'b0;
    check({name, "_ack_seen"}, 32'(seen), 1);
    check({name, "_latency"}, 32'(cnt), 32'(exp_lat));
    check({name, "_wr_cycles"}, 32'(wr_cnt), 32'(we));
    check({name, "_other_ack"}, 32'(other_acks), 0);
    check({name, "_other_rdata"}, 32'(sel ? rdata0 : rdata1), 32'(other_before));
    if (!we) check({name, "_rdata"}, 32'(sel ? rdata1 : rdata0), 32'(exp_rd));
  endtask

  typedef struct {
    logic       sel;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    int         exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int order [4];
    int n_acks, cyc;
    vecs[0] = '{1'b0, 1'b1, 5'd5,  8'hA5, 8'h00, 2};
    vecs[1] = '{1'b1, 1'b0, 5'd5,  8'h00, 8'hA5, 3};
    vecs[2] = '{1'b1, 1'b1, 5'd31, 8'h5A, 8'h00, 2};
    vecs[3] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'h5A, 3};
    vecs[4] = '{1'b0, 1'b1, 5'd0,  8'hFF, 8'h00, 2};
    vecs[5] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'hFF, 3};
    vecs[6] = '{1'b0, 1'b0, 5'd5,  8'h00, 8'hA5, 3};
    vecs[7] = '{1'b1, 1'b0, 5'd31, 8'h00, 8'h5A, 3};

    rst = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    // Reset asserted before the first clock edge
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++)
      run($sformatf("vec%0d", k), vecs[k].sel, vecs[k].we, vecs[k].addr,
          vecs[k].wdata, vecs[k].exp_rd, vecs[k].exp_lat, 1'b1, 1'b0);

    // Contention from reset: continuous reads, grants must alternate 0,1,0,1
    rst = 1'b1;
    preload(5'd0, 8'h11);
    preload(5'd31, 8'hEE);
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd31;
    n_acks = 0; cyc = 0;
    while (n_acks < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack0 && ack1) check("cont_dual_ack", 32'({ack0, ack1}), 32'b10);
      else if (ack0 || ack1) begin
        order[n_acks] = ack1 ? 1 : 0;
        n_acks++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("cont_ack_count", 32'(n_acks), 4);
    check("cont_cycles", 32'(cyc), 15);
    for (int k = 0; k < n_acks; k++)
      check($sformatf("cont_grant%0d", k), 32'(order[k]), 32'(k % 2));
    check("cont_rdata0", 32'(rdata0), 32'h11);
    check("cont_rdata1", 32'(rdata1), 32'hEE);
    @(negedge clk);

    // Back-to-back fill then read-back by requester 0
    for (int i = 0; i < 32; i++)
      run($sformatf("fill_w%0d", i), 1'b0, 1'b1, 5'(i), 8'(i * 3), 8'h00,
          (i == 0) ? 2 : 3, i == 0, 1'b0);
    for (int i = 0; i < 32; i++)
      run($sformatf("fill_r%0d", i), 1'b0, 1'b0, 5'(i), 8'h00, 8'(i * 3),
          4, 1'b0, 1'b0);

    // Protocol abuse: req1 drops and fields change during ACCESS of a write
    run("abuse_w", 1'b1, 1'b1, 5'd7, 8'h3C, 8'h00, 2, 1'b1, 1'b1);
    run("abuse_r", 1'b0, 1'b0, 5'd7, 8'h00, 8'h3C, 3, 1'b1, 1'b0);

    // Reset asserted mid-read during CAPTURE
    @(negedge clk);
    preload(5'd9, 8'h9C);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd9; wdata0 = 8'h77;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ack0 || ack1) n_acks++;
    end
    check("midrst_no_ack", 32'(n_acks), 0);
    check("midrst_idle", 32'(busy), 0);
    run("midrst_reread", 1'b0, 1'b0, 5'd9, 8'h00, 8'h9C, 3, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares the team's single-port 32x8 RAM (clk, rst, wr_re, addr, data_in, data_out).
- Each requester issues one read or write at a time with a req/ack handshake.
- The arbiter serialises the accesses, drives the RAM port, and returns read data.
- It sits between two client engines (e.g. DMA and CPU-side loader) and one RAM instance.

Parameters:
ADDR_W, 5, RAM address width (depth 2**ADDR_W)
DATA_W, 8, RAM data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req0  in  1  requester 0 access request, held until ack0
we0  in  1  requester 0: 1=write, 0=read; stable while req0
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
ack0  out  1  one-cycle completion pulse to requester 0
rdata0  out  DATA_W  requester 0 read data, valid when ack0 after a read, held until next read by requester 0
req1, we1, addr1, wdata1, ack1, rdata1  same as requester 0, for requester 1
mem_wr_re  out  1  RAM write enable (1=write, 0=read)
mem_addr  out  ADDR_W  RAM address
mem_data_in  out  DATA_W  RAM write data
mem_data_out  in  DATA_W  RAM registered read data (valid the cycle after the read edge)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst=1 asynchronously forces the following regardless of clk:
  - state=IDLE; ack0=ack1=0; rdata0=rdata1=0; mem_wr_re=0; mem_addr=0; mem_data_in=0; busy=0; rr pointer=0 (requester 0 favoured).
- Reset mid-operation aborts the transaction. No ack is issued; the RAM write may or may not have landed.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - Sample req0/req1 at the rising edge.
  - Grant rules: if only one is high, grant it. If both are high, grant the requester the rr pointer indicates.
  - On grant: latch the owner id, we, addr and wdata into mem_wr_re (=we), mem_addr and mem_data_in, then go to ACCESS.
  - With no request, stay in IDLE with mem_wr_re=0.
- ACCESS (1 cycle): RAM command is stable; the RAM samples at the edge ending this cycle.
  - Write: next state RESP; mem_wr_re returns to 0 at this edge.
  - Read: next state CAPTURE.
- CAPTURE (reads only, 1 cycle): mem_data_out holds mem[addr]. It is registered into the owner's rdata at the edge ending this cycle. Next state RESP.
- RESP (1 cycle): the owner's ack=1. The rr pointer moves to the non-owner at the edge ending RESP. Next state IDLE.
- Latency from the req-sampling edge to ack high: write = 2 cycles (ACCESS, RESP); read = 3 cycles (ACCESS, CAPTURE, RESP).
- Peak throughput: one write per 3 cycles, one read per 4 cycles.
- Handshake:
  - Requester keeps req, we, addr and wdata stable until it sees ack, then drops req by the next edge.
  - req still high in the IDLE cycle after ack is treated as a new request.
- Fields change or req drops before ack: the latched transaction still completes and ack still pulses. The new values are ignored until the next grant.
- Fairness: with both reqs continuously high, grants alternate 0,1,0,1. A requester waits at most one other transaction.
- Non-owner rdata never changes. The non-owner ack stays 0.
- Same-address hazard: requester 0 writes A, then requester 1 reads A. The read returns the new data, because accesses are strictly serialised.
- Address wrap: none. mem_addr is the latched ADDR_W-bit value; 31 is a legal address.
- The RAM's own reset is driven separately. The arbiter never issues accesses while in reset.

Test Plan:
- Reset then single write: req0=1, we0=1, addr0=5, wdata0=8'hA5 -> mem_wr_re=1 with mem_addr=5 for exactly one cycle; ack0 pulses 2 cycles after the sampling edge; ack1 stays 0.
- Read back: after the above, req1=1, we1=0, addr1=5 -> ack1 pulses 3 cycles after sampling with rdata1=8'hA5; rdata0 unchanged.
- Contention: req0 and req1 both high continuously from reset with reads of addr 0 and addr 31 (preloaded 8'h11 and 8'hEE) -> grant order 0,1,0,1; rdata0=8'h11, rdata1=8'hEE.
- Back-to-back fill: requester 0 writes mem[i]=i*3 for i=0..31, then reads all 32 -> every rdata0 equals i*3; each write takes 3 cycles and each read 4 cycles.
- Reset mid-read: assert rst during CAPTURE -> all outputs go to 0 immediately with no ack; after release, a new req0 read of the same address completes normally.
- Protocol abuse: drop req1 in ACCESS of a write to addr 7 with 8'h3C -> ack1 still pulses; a later read of addr 7 returns 8'h3C.
